// File: rtl/store_queue.sv
// store_queue: in-order store reservation queue for the Tomasulo core.
// DEPTH entries in a circular FIFO. Each entry snoops the CDB for its pending
// base and data operands. Entries retire to the memory unit in program order
// through a valid/ready handshake. Flush (mispredict) empties the queue.
// Optional feature macro: STQ_LOAD_CHECK_EN builds the load-disambiguation
// comparators behind ld_conflict. When it is undefined, ld_conflict is tied to 0.
module store_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CW    = 1 + TAG_W + DATA_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [CW-1:0]     cdb,
  input  logic              issue,
  input  logic [TAG_W-1:0]  q_base_in,
  input  logic [DATA_W-1:0] base_in,
  input  logic [DATA_W-1:0] offset_in,
  input  logic [TAG_W-1:0]  q_data_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        mem_u_b_h_w_in,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [DATA_W-1:0] st_addr,
  output logic [DATA_W-1:0] st_data,
  output logic [2:0]        st_mem_u_b_h_w,
  input  logic [DATA_W-1:0] ld_addr,
  output logic              ld_conflict
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  q_base;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] offset;
    logic [TAG_W-1:0]  q_data;
    logic [DATA_W-1:0] data;
    logic [2:0]        ctl;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            head_ent;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_d;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              fwd_base, fwd_data;
  logic              do_issue, do_disp;

  // CDB field split
  assign cdb_valid = cdb[CW-1];
  assign cdb_tag   = cdb[CW-2:DATA_W];
  assign cdb_data  = cdb[DATA_W-1:0];

  // Same-cycle forwarding of a CDB result into the entry being issued
  assign fwd_base = cdb_valid && (q_base_in != '0) && (cdb_tag == q_base_in);
  assign fwd_data = cdb_valid && (q_data_in != '0) && (cdb_tag == q_data_in);

  // Head entry drives the dispatch port; st_valid is independent of st_ready
  assign head_ent       = ent_q[head_q];
  assign st_valid       = head_ent.busy && (head_ent.q_base == '0) && (head_ent.q_data == '0);
  assign st_addr        = head_ent.base + head_ent.offset;
  assign st_data        = head_ent.data;
  assign st_mem_u_b_h_w = head_ent.ctl;

  // full is the pre-dispatch occupancy, so an issue into a full queue drops
  // even when the head leaves in the same cycle
  assign do_issue = issue && !full && !flush;
  assign do_disp  = st_valid && st_ready && !flush;

  // Next-state: CDB snoop, issue at tail, dispatch at head, flush override
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = count;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy && cdb_valid) begin
        if ((ent_q[i].q_base != '0) && (ent_q[i].q_base == cdb_tag)) begin
          ent_d[i].base   = cdb_data;
          ent_d[i].q_base = '0;
        end
        if ((ent_q[i].q_data != '0) && (ent_q[i].q_data == cdb_tag)) begin
          ent_d[i].data   = cdb_data;
          ent_d[i].q_data = '0;
        end
      end
    end

    if (do_issue) begin
      ent_d[tail_q].busy   = 1'b1;
      ent_d[tail_q].q_base = fwd_base ? '0 : q_base_in;
      ent_d[tail_q].base   = fwd_base ? cdb_data : base_in;
      ent_d[tail_q].offset = offset_in;
      ent_d[tail_q].q_data = fwd_data ? '0 : q_data_in;
      ent_d[tail_q].data   = fwd_data ? cdb_data : data_in;
      ent_d[tail_q].ctl    = mem_u_b_h_w_in;
      tail_d               = tail_q + PTR_W'(1);
    end

    if (do_disp) begin
      ent_d[head_q].busy = 1'b0;
      head_d             = head_q + PTR_W'(1);
    end

    unique case ({do_issue, do_disp})
      2'b10:   cnt_d = count + CNT_W'(1);
      2'b01:   cnt_d = count - CNT_W'(1);
      default: cnt_d = count;
    endcase

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_d[i].busy   = 1'b0;
        ent_d[i].q_base = '0;
        ent_d[i].q_data = '0;
      end
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // State registers; reset also clears every payload field
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count  <= cnt_d;
      full   <= (cnt_d == CNT_W'(DEPTH));
      empty  <= (cnt_d == '0);
    end
  end

`ifdef STQ_LOAD_CHECK_EN
  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

  // A load conflicts with any queued store whose address is unknown or
  // falls in the same word
  always_comb begin
    ld_conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        if (ent_q[i].q_base != '0) begin
          ld_conflict = 1'b1;
        end else if ((ent_q[i].base + ent_q[i].offset) >> 2 == ld_addr >> 2) begin
          ld_conflict = 1'b1;
        end
      end
    end
  end
`else
  logic unused_ld;
  assign unused_ld   = ^ld_addr;
  assign ld_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: table-driven stimulus with a dispatch scoreboard for store_queue.
module tb_store_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CW     = 1 + TAG_W + DATA_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [CW-1:0]     cdb;
  logic              issue;
  logic [TAG_W-1:0]  q_base_in;
  logic [DATA_W-1:0] base_in;
  logic [DATA_W-1:0] offset_in;
  logic [TAG_W-1:0]  q_data_in;
  logic [DATA_W-1:0] data_in;
  logic [2:0]        mem_u_b_h_w_in;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              st_valid;
  logic              st_ready;
  logic [DATA_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [2:0]        st_mem_u_b_h_w;
  logic [DATA_W-1:0] ld_addr;
  logic              ld_conflict;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cdb(cdb), .issue(issue),
    .q_base_in(q_base_in), .base_in(base_in), .offset_in(offset_in),
    .q_data_in(q_data_in), .data_in(data_in), .mem_u_b_h_w_in(mem_u_b_h_w_in),
    .full(full), .empty(empty), .count(count), .st_valid(st_valid),
    .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_mem_u_b_h_w(st_mem_u_b_h_w), .ld_addr(ld_addr), .ld_conflict(ld_conflict)
  );

  typedef struct {
    logic        iss;
    logic [7:0]  qb;
    logic [31:0] b;
    logic [31:0] o;
    logic [7:0]  qd;
    logic [31:0] d;
    logic [2:0]  c;
    logic [40:0] cdb;
    logic        rdy;
    logic        fl;
    logic        push;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        ev;
    int          ecnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic iss, input logic [7:0] qb, input logic [31:0] b,
                              input logic [31:0] o, input logic [7:0] qd, input logic [31:0] d,
                              input logic [2:0] c, input logic [40:0] cb, input logic rdy,
                              input logic fl, input logic push, input logic [31:0] sa,
                              input logic [31:0] sd, input logic ev, input int ecnt);
    vec_t v;
    v.iss = iss; v.qb = qb; v.b = b; v.o = o; v.qd = qd; v.d = d; v.c = c;
    v.cdb = cb; v.rdy = rdy; v.fl = fl; v.push = push; v.sa = sa; v.sd = sd;
    v.ev = ev; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic [40:0] cb, input logic rdy, input logic fl,
                                input logic ev, input int ecnt);
    return mk(1'b0, 8'h0, 32'h0, 32'h0, 8'h0, 32'h0, 3'h0, cb, rdy, fl, 1'b0, 32'h0, 32'h0, ev, ecnt);
  endfunction

  function automatic logic [40:0] bus(input logic [7:0] tag, input logic [31:0] val);
    return {1'b1, tag, val};
  endfunction

  // Drive one vector, advance one clock, check occupancy and handshake state
  task automatic apply(input vec_t v, input string tag);
    issue = v.iss; q_base_in = v.qb; base_in = v.b; offset_in = v.o;
    q_data_in = v.qd; data_in = v.d; mem_u_b_h_w_in = v.c;
    cdb = v.cdb; st_ready = v.rdy; flush = v.fl;
    if (v.push) sb.push_back({v.sa, v.sd, v.c});
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(st_valid), 32'(v.ev));
    check({tag, "_count"}, 32'(count), 32'(v.ecnt));
    check({tag, "_empty"}, 32'(empty), 32'(v.ecnt == 0));
    check({tag, "_full"},  32'(full),  32'(v.ecnt == int'(DEPTH)));
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected store
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && !flush && st_valid && st_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_dispatch: got addr %0h data %0h, expected none", st_addr, st_data);
      end else begin
        e = sb.pop_front();
        check("disp_addr", st_addr, e.a);
        check("disp_data", st_data, e.d);
        check("disp_ctl",  32'(st_mem_u_b_h_w), 32'(e.c));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [40:0] nob;
    logic        lc_en;
`ifdef STQ_LOAD_CHECK_EN
    lc_en = 1'b1;
`else
    lc_en = 1'b0;
`endif
    nob = '0;

    rst = 1'b1; flush = 1'b0; cdb = '0; issue = 1'b0; q_base_in = '0; base_in = '0;
    offset_in = '0; q_data_in = '0; data_in = '0; mem_u_b_h_w_in = '0; st_ready = 1'b0;
    ld_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_full",  32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_addr",  st_addr, 32'd0);
    check("rst_data",  st_data, 32'd0);
    check("rst_ctl",   32'(st_mem_u_b_h_w), 32'd0);
    check("rst_ldc",   32'(ld_conflict), 32'd0);

    // basic issue / dispatch, CDB wakeup and forwarding
    vt.push_back(mk(1, 0, 32'h100, 32'h8, 0, 32'hDEADBEEF, 3'd2, nob, 0, 0, 1, 32'h108, 32'hDEADBEEF, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    vt.push_back(mk(1, 0, 32'h40, 32'h4, 8'd5, 32'h0, 3'd1, nob, 0, 0, 1, 32'h44, 32'h1234, 0, 1));
    vt.push_back(idle(bus(8'd6, 32'h9999), 0, 0, 0, 1));
    vt.push_back(idle({1'b0, 8'd5, 32'h8888}, 0, 0, 0, 1));
    vt.push_back(idle(bus(8'd5, 32'h1234), 0, 0, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    vt.push_back(mk(1, 0, 32'h10, 32'hFFFFFFFC, 8'd7, 32'h0, 3'd3, bus(8'd7, 32'hCAFE), 0, 0, 1, 32'hC, 32'hCAFE, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'd9, 32'h5555, 32'h20, 0, 32'hA5, 3'd4, nob, 0, 0, 1, 32'h320, 32'hA5, 0, 1));
    vt.push_back(idle(bus(8'd9, 32'h300), 0, 0, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'd6, 32'h0, 32'h1, 8'd6, 32'h0, 3'd6, nob, 0, 0, 1, 32'h1001, 32'h1000, 0, 1));
    vt.push_back(idle(bus(8'd6, 32'h1000), 0, 0, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    // fill, drop on full, full+dispatch corner, drain through pointer wrap
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1, 0, 32'h1000 + 32'(i * 16), 32'h0, 0, 32'hA0 + 32'(i), 3'(i), nob, 0, 0, 1,
                      32'h1000 + 32'(i * 16), 32'hA0 + 32'(i), 1, i + 1));
    vt.push_back(mk(1, 0, 32'hBAD0, 32'h0, 0, 32'hBAD, 3'd7, nob, 0, 0, 0, 0, 0, 1, 4));
    vt.push_back(mk(1, 0, 32'hBAD4, 32'h0, 0, 32'hBAD, 3'd7, nob, 1, 0, 0, 0, 0, 1, 3));
    vt.push_back(mk(1, 0, 32'h1040, 32'h0, 0, 32'hA4, 3'd5, nob, 1, 0, 1, 32'h1040, 32'hA4, 1, 3));
    vt.push_back(idle(nob, 1, 0, 1, 2));
    vt.push_back(idle(nob, 1, 0, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    // non-ready head blocks a ready younger entry
    vt.push_back(mk(1, 0, 32'h2000, 32'h0, 8'd3, 32'h0, 3'd1, nob, 0, 0, 1, 32'h2000, 32'h77, 0, 1));
    vt.push_back(mk(1, 0, 32'h2010, 32'h0, 0, 32'h88, 3'd2, nob, 1, 0, 1, 32'h2010, 32'h88, 0, 2));
    vt.push_back(idle(nob, 1, 0, 0, 2));
    vt.push_back(idle(bus(8'd3, 32'h77), 1, 0, 1, 2));
    vt.push_back(idle(nob, 1, 0, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));
    // flush with concurrent issue and ready; stale tags must not revive entries
    vt.push_back(mk(1, 0, 32'h3000, 32'h0, 0, 32'h1, 3'd0, nob, 0, 0, 0, 0, 0, 1, 1));
    vt.push_back(mk(1, 0, 32'h3010, 32'h0, 8'h11, 32'h0, 3'd0, nob, 0, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk(1, 8'h12, 32'h0, 32'h0, 0, 32'h2, 3'd0, nob, 0, 0, 0, 0, 0, 1, 3));
    vt.push_back(mk(1, 0, 32'h3030, 32'h0, 0, 32'h3, 3'd0, nob, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(idle(bus(8'h11, 32'h5), 0, 0, 0, 0));
    vt.push_back(idle(bus(8'h12, 32'h6), 1, 0, 0, 0));
    vt.push_back(mk(1, 0, 32'h4000, 32'h10, 0, 32'h55, 3'd5, nob, 0, 0, 1, 32'h4010, 32'h55, 1, 1));
    vt.push_back(idle(nob, 1, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("v%0d", i));

    // load disambiguation sequence
    apply(mk(1, 0, 32'h200, 32'h0, 0, 32'h1, 3'd0, nob, 0, 0, 1, 32'h200, 32'h1, 1, 1), "ld0");
    ld_addr = 32'h202; #1;
    check("ldc_same_word", 32'(ld_conflict), 32'(lc_en));
    ld_addr = 32'h204; #1;
    check("ldc_next_word", 32'(ld_conflict), 32'd0);
    apply(mk(1, 8'd5, 32'h0, 32'h4, 0, 32'h2, 3'd1, nob, 0, 0, 1, 32'h404, 32'h2, 1, 2), "ld1");
    check("ldc_unknown_base", 32'(ld_conflict), 32'(lc_en));
    apply(idle(bus(8'd5, 32'h400), 0, 0, 1, 2), "ld2");
    check("ldc_base_resolved", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h407; #1;
    check("ldc_second_entry", 32'(ld_conflict), 32'(lc_en));
    apply(idle(nob, 1, 0, 1, 1), "ld3");
    apply(idle(nob, 1, 0, 0, 0), "ld4");
    ld_addr = 32'h202; #1;
    check("ldc_after_dispatch", 32'(ld_conflict), 32'd0);

    st_ready = 1'b0;
    @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

Multi-entry, in-order store reservation queue for the Tomasulo core. It generalises the single store reservation line to DEPTH entries held in a circular FIFO. Each entry snoops the CDB for a pending address-base operand and a pending data operand. Entries retire to the memory unit strictly in program order through a valid/ready handshake, and the whole queue clears on branch mispredict.

## Interface
- DEPTH, 4: entry count; power of two, ≥2.
- TAG_W, 8: tag width; tag 0 means "operand available".
- DATA_W, 32: data and address width.
- CW = 1+TAG_W+DATA_W (derived): CDB width. Valid is bit CW-1, tag is [CW-2:DATA_W], data is [DATA_W-1:0].
- CNT_W = $clog2(DEPTH+1) (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict; empties the queue.
- cdb  in  CW  common data bus.
- issue  in  1  push a new store.
- q_base_in  in  TAG_W  base-register tag.
- base_in  in  DATA_W  base value.
- offset_in  in  DATA_W  sign-extended immediate.
- q_data_in  in  TAG_W  data tag.
- data_in  in  DATA_W  data value.
- mem_u_b_h_w_in  in  3  width/sign control.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  CNT_W  occupied entries.
- st_valid  out  1  head entry ready to dispatch.
- st_ready  in  1  memory unit accepts.
- st_addr  out  DATA_W  head address.
- st_data  out  DATA_W  head data.
- st_mem_u_b_h_w  out  3  head control.
- ld_addr  in  DATA_W  load address for disambiguation.
- ld_conflict  out  1  older store may alias ld_addr.

## Operation
- Per-entry state: busy, q_base, base, offset, q_data, data, mem_u_b_h_w. Queue pointers are head and tail (log2 DEPTH bits, natural wrap) plus count.
- Issue:
  - Accepted only when issue && !full && !flush.
  - Writes the entry at tail, tail+1, busy=1.
  - Same-cycle CDB forwarding per operand: if cdb valid and cdb tag equals a nonzero q_*_in, the entry stores the CDB data and tag 0. Otherwise it stores the input tag and value.
  - issue while full is dropped silently; the producer must gate on full.
- Snoop: every busy entry with q_x≠0 and cdb valid with tag==q_x loads the CDB data into the operand and clears q_x. Both operands of one entry may match in the same cycle.
- Ready: entry ready = busy && q_base==0 && q_data==0.
- Address: base+offset, modulo 2^DATA_W, computed combinationally from the head entry.
- Dispatch:
  - st_valid = head ready. st_addr, st_data and st_mem_u_b_h_w come from the head entry.
  - On st_valid && st_ready at a clock edge: head entry busy=0, head+1.
  - A younger ready entry never bypasses a non-ready head.
- count: +1 on accepted issue, −1 on dispatch, unchanged when both occur in the same cycle.
- Full corner case: with count==DEPTH, simultaneous issue and dispatch drops the issue (full is evaluated before the dispatch) and dispatches the head, so count becomes DEPTH−1.
- Flush: highest priority. All busy=0, all tags=0, head=tail=0, count=0. Same-cycle issue and dispatch are ignored; st_ready is a don't-care.
- Reset: same effect as flush, plus every operand, offset and control field is cleared to 0.

## Timing
- Every state change happens on posedge clk. rst is sampled synchronously.
- Reset values:
  - full=0, empty=1, count=0, st_valid=0, st_addr=0, st_data=0, st_mem_u_b_h_w=0, ld_conflict=0.
- Issue with both operands available (or CDB-forwarded): the entry is ready in the next cycle. For an empty queue, st_valid is high in the cycle after issue (1-cycle latency).
- CDB broadcast in cycle N for a pending operand: that operand is usable, and st_valid can go high, in cycle N+1.
- Handshake:
  - st_valid never depends on st_ready.
  - Once st_valid is high, it and the payload stay stable until accepted or flushed.
  - Back-to-back dispatch: one store per cycle.
- Pointer wrap from DEPTH−1 to 0 has no bubble.

## Configuration
- STQ_LOAD_CHECK_EN defined: ld_conflict is computed combinationally. It is 1 if any busy entry has q_base≠0 (address unknown), or its base+offset equals ld_addr when both are compared with bits [1:0] cleared (word match).
- STQ_LOAD_CHECK_EN not defined: the ld_conflict port is still present and tied to 0, and no comparators are built.

## Test plan
- Reset → issue store base=0x100, off=0x8, data=0xDEADBEEF, both tags 0 → next cycle st_valid=1, st_addr=0x108, st_data=0xDEADBEEF. With st_ready=1: empty=1 one cycle later.
- Issue with q_data=5 → st_valid=0. CDB {1,5,0x1234} in cycle N → st_valid=1 in N+1 with st_data=0x1234. Also: issue with q_data_in=7 while the CDB carries tag 7 → forwarded at issue, tag cleared.
- Fill 4 entries, st_ready=0 → full=1, count=4. Issue while full → dropped. Issue + st_ready in the same cycle while full → count=3. Continue through pointer wrap → stores leave in issue order.
- Head waits on q_data=3 while entry 1 is ready → st_valid stays 0 (no bypass). CDB tag 3 → head dispatches, then entry 1 next cycle.
- With 3 entries busy: assert flush together with issue and st_ready → count=0, empty=1, st_valid=0. A later CDB tag matching an old q does not revive any entry.
- (STQ_LOAD_CHECK_EN) Entry address 0x200 busy: ld_addr=0x202 → ld_conflict=1; ld_addr=0x204 → 0. An entry with q_base≠0 → 1. After that store dispatches → 0.
